// File: rtl/traffic_signal_ctrl.sv
// traffic_signal_ctrl: actuated round-robin traffic-signal controller.
// Each approach is served GREEN -> YELLOW -> ALLRED; approaches without
// a vehicle request are skipped, and green is held while nobody else waits.
// Lamp outputs are registered from the current state, so they follow a
// state change by one clock edge.
// Optional feature: define PED_WALK_EN to add the ped_req_i/walk_o ports
// and a pedestrian WALK interval inserted after the all-red clearance.
module traffic_signal_ctrl #(
  parameter int NUM_DIR    = 4,
  parameter int GREEN_CYC  = 8,
  parameter int YELLOW_CYC = 3,
  parameter int ALLRED_CYC = 2,
  parameter int WALK_CYC   = 6,
  parameter int CNT_W      = $clog2(
    (GREEN_CYC >= YELLOW_CYC && GREEN_CYC >= ALLRED_CYC && GREEN_CYC >= WALK_CYC) ? GREEN_CYC :
    (YELLOW_CYC >= ALLRED_CYC && YELLOW_CYC >= WALK_CYC) ? YELLOW_CYC :
    (ALLRED_CYC >= WALK_CYC) ? ALLRED_CYC : WALK_CYC) + 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_DIR-1:0]         req_i,
  output logic [NUM_DIR-1:0]         go_o,
  output logic [NUM_DIR-1:0]         caution_o,
  output logic [NUM_DIR-1:0]         stop_o,
  output logic [$clog2(NUM_DIR)-1:0] phase_o
`ifdef PED_WALK_EN
  ,
  input  logic                       ped_req_i,
  output logic                       walk_o
`endif
);

  localparam int IDX_W = $clog2(NUM_DIR);

  // S_ALLRED_POST is the clearance after a WALK; it always returns to GREEN.
  typedef enum logic [2:0] {
    S_GREEN,
    S_YELLOW,
    S_ALLRED,
    S_WALK,
    S_ALLRED_POST
  } state_e;

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [IDX_W-1:0]   cur_q;
  logic [IDX_W-1:0]   nxt_q;

  logic [NUM_DIR-1:0] rot;
  logic [IDX_W-1:0]   nxt_sel;
  logic               foreign;
  logic               demand;

  // Rotate requests so bit k is approach cur+k; pick the nearest foreign requester.
  always_comb begin
    // NOTE: every variable gets a default before any conditional write, so no latch is inferred.
    rot     = NUM_DIR'({req_i, req_i} >> cur_q);
    nxt_sel = cur_q;
    // Walk downwards so the smallest distance wins.
    for (int k = NUM_DIR - 1; k >= 1; k--) begin
      if (rot[k]) nxt_sel = IDX_W'((int'(cur_q) + k) % NUM_DIR);
    end
    foreign = |rot[NUM_DIR-1:1];
  end

`ifdef PED_WALK_EN
  logic ped_prev_q;
  logic ped_pend_q;
  logic ped_rise;
  assign ped_rise = ped_req_i & ~ped_prev_q;
  assign demand   = foreign | ped_pend_q;
`else
  assign demand   = foreign;
`endif

  // Phase sequencing, pedestrian latch and registered lamp decode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_GREEN;
      cnt_q     <= '0;
      cur_q     <= '0;
      nxt_q     <= '0;
      go_o      <= NUM_DIR'(1);
      caution_o <= '0;
      stop_o    <= ~NUM_DIR'(1);
      phase_o   <= '0;
`ifdef PED_WALK_EN
      ped_prev_q <= 1'b0;
      ped_pend_q <= 1'b0;
      walk_o     <= 1'b0;
`endif
    end else begin
      // Lamps reflect the state held during the cycle that just ended.
      // NOTE: non-blocking assignments throughout; later assignments in this block override earlier defaults.
      go_o      <= '0;
      caution_o <= '0;
      stop_o    <= '1;
      phase_o   <= cur_q;
      case (state_q)
        S_GREEN: begin
          go_o   <= NUM_DIR'(1) << cur_q;
          stop_o <= ~(NUM_DIR'(1) << cur_q);
        end
        S_YELLOW: begin
          caution_o <= NUM_DIR'(1) << cur_q;
          stop_o    <= ~(NUM_DIR'(1) << cur_q);
        end
        default: ;
      endcase

`ifdef PED_WALK_EN
      walk_o     <= (state_q == S_WALK);
      ped_prev_q <= ped_req_i;
      if (ped_rise) ped_pend_q <= 1'b1;
`endif

      cnt_q <= cnt_q + 1'b1;
      case (state_q)
        S_GREEN: begin
          if (cnt_q == CNT_W'(GREEN_CYC - 1)) begin
            if (demand) begin
              nxt_q   <= nxt_sel;
              state_q <= S_YELLOW;
              cnt_q   <= '0;
            end else begin
              cnt_q   <= cnt_q;  // saturate: hold green until demand appears
            end
          end
        end
        S_YELLOW: begin
          if (cnt_q == CNT_W'(YELLOW_CYC - 1)) begin
            state_q <= S_ALLRED;
            cnt_q   <= '0;
          end
        end
        S_ALLRED: begin
          if (cnt_q == CNT_W'(ALLRED_CYC - 1)) begin
            cnt_q <= '0;
`ifdef PED_WALK_EN
            if (ped_pend_q) begin
              state_q    <= S_WALK;
              ped_pend_q <= ped_rise;  // consumed, unless a new press lands now
            end else begin
              state_q <= S_GREEN;
              cur_q   <= nxt_q;
            end
`else
            state_q <= S_GREEN;
            cur_q   <= nxt_q;
`endif
          end
        end
        S_WALK: begin
          if (cnt_q == CNT_W'(WALK_CYC - 1)) begin
            state_q <= S_ALLRED_POST;
            cnt_q   <= '0;
          end
        end
        S_ALLRED_POST: begin
          if (cnt_q == CNT_W'(ALLRED_CYC - 1)) begin
            state_q <= S_GREEN;
            cur_q   <= nxt_q;
            cnt_q   <= '0;
          end
        end
        default: begin
          state_q <= S_GREEN;
          cnt_q   <= '0;
        end
      endcase
    end
  end

endmodule
